// File: rtl/mine_pkg.sv
// Shared definitions for the mine placement engine: FSM states, grid sizing
// helpers and the modulus value that selects full-width LCG wraparound.
package mine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_DRAW,
    ST_PROBE,
    ST_DONE
  } state_t;

  // A modulus of this value means "wrap at 2^SEED_W" rather than divide.
  localparam int MOD_FULL_RANGE = 0;

  function automatic int calc_cells(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int calc_iw(input int cells);
    return (cells <= 1) ? 1 : $clog2(cells);
  endfunction

endpackage

// File: rtl/mine_lcg.sv
// Combinational LCG step: X_new = (a*X + c) mod m, with m=0 meaning a
// plain SEED_W-bit truncation of the double-width result.
module mine_lcg
  import mine_pkg::*;
#(
  parameter int SEED_W = 16
) (
  input  logic [SEED_W-1:0] in_x,
  input  logic [SEED_W-1:0] in_mult,
  input  logic [SEED_W-1:0] in_increment,
  input  logic [SEED_W-1:0] in_modulus,
  output logic [SEED_W-1:0] out_x
);

  logic [2*SEED_W-1:0] w_sum;
  logic [2*SEED_W-1:0] w_modulus_wide;

  // The sum cannot overflow 2*SEED_W bits because (2^W-1)^2 + 2^W-1 < 2^2W.
  always_comb begin
    w_sum          = (2*SEED_W)'(in_mult) * (2*SEED_W)'(in_x) + (2*SEED_W)'(in_increment);
    w_modulus_wide = (2*SEED_W)'(in_modulus);
    if (in_modulus == SEED_W'(MOD_FULL_RANGE)) begin
      out_x = w_sum[SEED_W-1:0];
    end else begin
      out_x = SEED_W'(w_sum % w_modulus_wide);
    end
  end

endmodule

// File: rtl/mine_placer.sv
// Places a run-time number of unique mines on a ROWS x COLS board using an LCG
// with linear probing. Optional MINE_PLACER_SAFE_CELL_EN reserves one mine-free cell.
module mine_placer
  import mine_pkg::*;
#(
  parameter int  ROWS   = 5,
  parameter int  COLS   = 5,
  parameter int  SEED_W = 16,
  localparam int N      = calc_cells(ROWS, COLS),
  localparam int IW     = calc_iw(N)
) (
  input  logic              in_clka,
  input  logic              in_reset,
  input  logic              in_start,
  input  logic [SEED_W-1:0] in_seed,
  input  logic [SEED_W-1:0] in_mult,
  input  logic [SEED_W-1:0] in_increment,
  input  logic [SEED_W-1:0] in_modulus,
  input  logic [IW:0]       in_num_mines,
`ifdef MINE_PLACER_SAFE_CELL_EN
  input  logic [IW-1:0]     in_safe_cell,
`endif
  output logic [N-1:0]      out_mines,
  output logic              out_busy,
  output logic              out_done
);

`ifdef MINE_PLACER_SAFE_CELL_EN
  localparam logic [IW:0] MAX_TARGET = (IW+1)'(N - 1);
`else
  localparam logic [IW:0] MAX_TARGET = (IW+1)'(N);
`endif
  localparam logic [SEED_W-1:0] N_MOD     = SEED_W'(N);
  localparam logic [IW-1:0]     LAST_CELL = IW'(N - 1);

  state_t              r_state;
  logic [SEED_W-1:0]   r_x;
  logic [SEED_W-1:0]   r_seed;
  logic [SEED_W-1:0]   r_mult;
  logic [SEED_W-1:0]   r_increment;
  logic [SEED_W-1:0]   r_modulus;
  logic [IW:0]         r_target;
  logic [IW:0]         r_count;
  logic [IW-1:0]       r_probe;
  logic [N-1:0]        r_mines;
  logic                r_busy;
  logic                r_done;

  logic [SEED_W-1:0]   w_x_new;
  logic [IW-1:0]       w_idx;
  logic [IW-1:0]       w_idx_next;
  logic [IW-1:0]       w_probe_next;
  logic [IW:0]         w_count_inc;
  logic                w_last;
  logic [N-1:0]        w_blocked;

  mine_lcg #(.SEED_W(SEED_W)) u_lcg (
    .in_x        (r_x),
    .in_mult     (r_mult),
    .in_increment(r_increment),
    .in_modulus  (r_modulus),
    .out_x       (w_x_new)
  );

`ifdef MINE_PLACER_SAFE_CELL_EN
  logic [IW-1:0] r_safe;
  always_ff @(posedge in_clka) begin
    if (in_reset) begin
      r_safe <= '0;
    end else if (r_state == ST_IDLE && in_start) begin
      r_safe <= in_safe_cell;
    end
  end
  assign w_blocked = r_mines | (N'(1) << r_safe);
`else
  assign w_blocked = r_mines;
`endif

  assign w_idx        = IW'(w_x_new % N_MOD);
  assign w_idx_next   = (w_idx == LAST_CELL) ? '0 : w_idx + 1'b1;
  assign w_probe_next = (r_probe == LAST_CELL) ? '0 : r_probe + 1'b1;
  assign w_count_inc  = r_count + 1'b1;
  assign w_last       = (w_count_inc == r_target);

  // Every state that places the final mine hands off straight to DONE so
  // busy drops and done rises on the same edge.
  always_ff @(posedge in_clka) begin
    if (in_reset) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_seed      <= '0;
      r_mult      <= '0;
      r_increment <= '0;
      r_modulus   <= '0;
      r_target    <= '0;
      r_count     <= '0;
      r_probe     <= '0;
      r_mines     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_start) begin
            r_seed      <= in_seed;
            r_mult      <= in_mult;
            r_increment <= in_increment;
            r_modulus   <= in_modulus;
            r_target    <= (in_num_mines > MAX_TARGET) ? MAX_TARGET : in_num_mines;
            r_busy      <= 1'b1;
            r_state     <= ST_SEED;
          end
        end
        ST_SEED: begin
          r_x     <= r_seed;
          r_mines <= '0;
          r_count <= '0;
          if (r_target == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          r_x <= w_x_new;
          if (!w_blocked[w_idx]) begin
            r_mines[w_idx] <= 1'b1;
            r_count        <= w_count_inc;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else begin
            r_probe <= w_idx_next;
            r_state <= ST_PROBE;
          end
        end
        ST_PROBE: begin
          if (!w_blocked[r_probe]) begin
            r_mines[r_probe] <= 1'b1;
            r_count          <= w_count_inc;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_DRAW;
            end
          end else begin
            r_probe <= w_probe_next;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_mines = r_mines;
  assign out_busy  = r_busy;
  assign out_done  = r_done;

endmodule

// File: tb/tb_mine_placer.sv
// Self-checking bench for mine_placer on a 5x5 board; compares the DUT with a
// placement model built from the LCG and linear-probe rules.
module tb_mine_placer;

  localparam int CELLS = 25;
  localparam int TIMEOUT = 2000;

  logic        clk;
  logic        inReset;
  logic        inStart;
  logic [15:0] inSeed;
  logic [15:0] inMult;
  logic [15:0] inIncrement;
  logic [15:0] inModulus;
  logic [5:0]  inNumMines;
`ifdef MINE_PLACER_SAFE_CELL_EN
  logic [4:0]  safeCell;
`endif
  logic [24:0] outMines;
  logic        outBusy;
  logic        outDone;

  int total = 0;
  int bad   = 0;

  mine_placer #(.ROWS(5), .COLS(5), .SEED_W(16)) dut (
    .in_clka     (clk),
    .in_reset    (inReset),
    .in_start    (inStart),
    .in_seed     (inSeed),
    .in_mult     (inMult),
    .in_increment(inIncrement),
    .in_modulus  (inModulus),
    .in_num_mines(inNumMines),
`ifdef MINE_PLACER_SAFE_CELL_EN
    .in_safe_cell(safeCell),
`endif
    .out_mines   (outMines),
    .out_busy    (outBusy),
    .out_done    (outDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference placement: one LCG step per mine, walk forward past taken cells.
  // lat counts rising edges from the start-sampling edge to the done pulse.
  function automatic void model_run(input logic [15:0] seed, input logic [15:0] a,
                                    input logic [15:0] c, input logic [15:0] m,
                                    input int nm, input int safe,
                                    output logic [24:0] mines, output int lat);
    longint x;
    int target;
    int maxT;
    int idx;
    maxT   = (safe >= 0) ? CELLS - 1 : CELLS;
    target = (nm > maxT) ? maxT : nm;
    x      = longint'(seed);
    mines  = '0;
    lat    = 1;
    for (int k = 0; k < target; k++) begin
      if (m == 16'd0) x = (longint'(a) * x + longint'(c)) % 65536;
      else            x = (longint'(a) * x + longint'(c)) % longint'(m);
      idx = int'(x % CELLS);
      while (mines[idx] == 1'b1 || idx == safe) begin
        idx = (idx + 1) % CELLS;
        lat++;
      end
      mines[idx] = 1'b1;
      lat++;
    end
  endfunction

  // Drives one run and reports what the DUT did; optionally disturbs the
  // start and configuration inputs while the run is in progress.
  task automatic run_dut(input logic [15:0] seed, input logic [15:0] a,
                         input logic [15:0] c, input logic [15:0] m,
                         input logic [5:0] nm, input logic [4:0] safe,
                         input bit disturb,
                         output logic [24:0] mines, output int cycles,
                         output bit busyOk, output bit timedOut);
    @(negedge clk);
    inSeed      = seed;
    inMult      = a;
    inIncrement = c;
    inModulus   = m;
    inNumMines  = nm;
`ifdef MINE_PLACER_SAFE_CELL_EN
    safeCell    = safe;
`else
    if (safe != 5'd0) begin end
`endif
    inStart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inStart  = 1'b0;
    cycles   = 0;
    busyOk   = 1'b1;
    timedOut = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (outDone) begin
        busyOk   = busyOk && !outBusy;
        timedOut = 1'b0;
        break;
      end
      busyOk = busyOk && outBusy;
      if (disturb && cycles == 3) begin
        inStart     = 1'b1;
        inSeed      = 16'($urandom);
        inMult      = 16'($urandom);
        inIncrement = 16'($urandom);
        inModulus   = 16'($urandom);
        inNumMines  = 6'($urandom);
      end
      if (disturb && cycles == 4) inStart = 1'b0;
    end
    inStart = 1'b0;
    mines   = outMines;
  endtask

  task automatic test_reset;
    inReset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (outMines !== 25'd0) begin
      bad++; $display("[TB] FAIL reset_mines: got %h want %h", outMines, 25'd0);
    end
    total++;
    if (outBusy !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_busy: got %b want 0", outBusy);
    end
    total++;
    if (outDone !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_done: got %b want 0", outDone);
    end
    inReset = 1'b0;
  endtask

  task automatic test_directed;
    logic [24:0] mines;
    logic [24:0] held;
    int cycles;
    bit busyOk, timedOut;
    logic [24:0] expMines2;
    int expLat2;
`ifdef MINE_PLACER_SAFE_CELL_EN
    expMines2 = 25'h00001A0; expLat2 = 9;
`else
    expMines2 = 25'h00000E0; expLat2 = 7;
`endif
    run_dut(16'd0, 16'd5, 16'd3, 16'd16, 6'd5, 5'd24, 1'b0, mines, cycles, busyOk, timedOut);
    total++;
    if (timedOut) begin bad++; $display("[TB] FAIL lcg5_timeout: no done within %0d cycles", TIMEOUT); end
    total++;
    if (mines !== 25'h000209C) begin bad++; $display("[TB] FAIL lcg5_mines: got %h want %h", mines, 25'h000209C); end
    total++;
    if (cycles != 6) begin bad++; $display("[TB] FAIL lcg5_latency: got %0d want 6", cycles); end
    total++;
    if (!busyOk) begin bad++; $display("[TB] FAIL lcg5_busy: busy not high until done or not low at done"); end
    held = outMines;
    @(negedge clk);
    total++;
    if (outDone !== 1'b0) begin bad++; $display("[TB] FAIL done_pulse_width: got %b want 0", outDone); end
    repeat (3) @(negedge clk);
    total++;
    if (outMines !== held) begin bad++; $display("[TB] FAIL mines_hold: got %h want %h", outMines, held); end

    run_dut(16'd5, 16'd1, 16'd0, 16'd16, 6'd3, 5'd6, 1'b0, mines, cycles, busyOk, timedOut);
    total++;
    if (mines !== expMines2) begin bad++; $display("[TB] FAIL probe_mines: got %h want %h", mines, expMines2); end
    total++;
    if (cycles != expLat2) begin bad++; $display("[TB] FAIL probe_latency: got %0d want %0d", cycles, expLat2); end
    total++;
    if (!busyOk || timedOut) begin bad++; $display("[TB] FAIL probe_handshake: busyOk=%0d timedOut=%0d", busyOk, timedOut); end
  endtask

  task automatic test_clamp;
    logic [24:0] mines, expMines;
    int cycles, expLat, safe;
    bit busyOk, timedOut;
`ifdef MINE_PLACER_SAFE_CELL_EN
    safe = 0;
`else
    safe = -1;
`endif
    model_run(16'd9, 16'd5, 16'd3, 16'd16, 30, safe, expMines, expLat);
    run_dut(16'd9, 16'd5, 16'd3, 16'd16, 6'd30, 5'd0, 1'b0, mines, cycles, busyOk, timedOut);
    total++;
`ifdef MINE_PLACER_SAFE_CELL_EN
    if (mines !== 25'h1FFFFFE) begin bad++; $display("[TB] FAIL clamp_full: got %h want %h", mines, 25'h1FFFFFE); end
`else
    if (mines !== 25'h1FFFFFF) begin bad++; $display("[TB] FAIL clamp_full: got %h want %h", mines, 25'h1FFFFFF); end
`endif
    total++;
    if (cycles != expLat || timedOut) begin bad++; $display("[TB] FAIL clamp_latency: got %0d want %0d", cycles, expLat); end

    run_dut(16'd9, 16'd5, 16'd3, 16'd16, 6'd0, 5'd0, 1'b0, mines, cycles, busyOk, timedOut);
    total++;
    if (mines !== 25'd0) begin bad++; $display("[TB] FAIL zero_mines: got %h want 0", mines); end
    total++;
    if (cycles != 1 || timedOut) begin bad++; $display("[TB] FAIL zero_latency: got %0d want 1", cycles); end
    total++;
    if (!busyOk) begin bad++; $display("[TB] FAIL zero_busy: busy still high with done"); end
  endtask

  task automatic test_reset_midrun;
    logic [24:0] mines, expMines;
    int cycles, expLat, safe;
    bit busyOk, timedOut, doneSeen;
`ifdef MINE_PLACER_SAFE_CELL_EN
    safe = 24;
    safeCell = 5'd24;
`else
    safe = -1;
`endif
    @(negedge clk);
    inSeed = 16'd0; inMult = 16'd5; inIncrement = 16'd3; inModulus = 16'd16; inNumMines = 6'd5;
    inStart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inStart = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    inReset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inReset = 1'b0;
    total++;
    if (outBusy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b want 0", outBusy); end
    total++;
    if (outMines !== 25'd0) begin bad++; $display("[TB] FAIL midreset_mines: got %h want 0", outMines); end
    doneSeen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      doneSeen = doneSeen || outDone || outBusy;
    end
    total++;
    if (doneSeen !== 1'b0) begin bad++; $display("[TB] FAIL midreset_idle: activity seen %b want 0", doneSeen); end
    model_run(16'd0, 16'd5, 16'd3, 16'd16, 5, safe, expMines, expLat);
    run_dut(16'd0, 16'd5, 16'd3, 16'd16, 6'd5, 5'd24, 1'b0, mines, cycles, busyOk, timedOut);
    total++;
    if (mines !== expMines || cycles != expLat || timedOut) begin
      bad++; $display("[TB] FAIL midreset_rerun: mines %h lat %0d want %h lat %0d", mines, cycles, expMines, expLat);
    end
  endtask

  task automatic test_ignore_start;
    logic [24:0] mines, expMines;
    int cycles, expLat, safe;
    bit busyOk, timedOut;
`ifdef MINE_PLACER_SAFE_CELL_EN
    safe = 6;
`else
    safe = -1;
`endif
    model_run(16'd5, 16'd1, 16'd0, 16'd16, 3, safe, expMines, expLat);
    run_dut(16'd5, 16'd1, 16'd0, 16'd16, 6'd3, 5'd6, 1'b1, mines, cycles, busyOk, timedOut);
    total++;
    if (mines !== expMines) begin bad++; $display("[TB] FAIL busy_start_mines: got %h want %h", mines, expMines); end
    total++;
    if (cycles != expLat || timedOut) begin bad++; $display("[TB] FAIL busy_start_latency: got %0d want %0d", cycles, expLat); end
  endtask

  task automatic test_back_to_back;
    logic [24:0] expMines;
    int cycles, expLat, safe;
    bit finished;
`ifdef MINE_PLACER_SAFE_CELL_EN
    safe = 24;
    safeCell = 5'd24;
`else
    safe = -1;
`endif
    model_run(16'd0, 16'd5, 16'd3, 16'd16, 5, safe, expMines, expLat);
    @(negedge clk);
    inSeed = 16'd0; inMult = 16'd5; inIncrement = 16'd3; inModulus = 16'd16; inNumMines = 6'd5;
    inStart = 1'b1;
    finished = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (outDone) begin finished = 1'b1; break; end
    end
    total++;
    if (!finished) begin bad++; $display("[TB] FAIL b2b_first_timeout: no done within %0d cycles", TIMEOUT); end
    @(negedge clk);
    total++;
    if (outBusy !== 1'b0 || outDone !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_idle_gap: busy %b done %b want 0 0", outBusy, outDone);
    end
    @(negedge clk);
    inStart = 1'b0;
    total++;
    if (outBusy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_restart: busy %b want 1", outBusy); end
    cycles = 0;
    finished = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (outDone) begin finished = 1'b1; break; end
    end
    total++;
    if (!finished || cycles != expLat || outMines !== expMines) begin
      bad++; $display("[TB] FAIL b2b_second_run: mines %h lat %0d want %h lat %0d", outMines, cycles, expMines, expLat);
    end
  endtask

  task automatic test_random;
    logic [24:0] mines, expMines;
    logic [15:0] seed, a, c, m;
    logic [5:0] nm;
    logic [4:0] safeIn;
    int cycles, expLat, safe;
    bit busyOk, timedOut;
    for (int t = 0; t < 16; t++) begin
      seed = 16'($urandom);
      a    = 16'($urandom);
      c    = 16'($urandom);
      m    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      nm   = 6'($urandom_range(0, 40));
      safeIn = 5'($urandom_range(0, CELLS - 1));
`ifdef MINE_PLACER_SAFE_CELL_EN
      safe = int'(safeIn);
`else
      safe = -1;
`endif
      model_run(seed, a, c, m, int'(nm), safe, expMines, expLat);
      run_dut(seed, a, c, m, nm, safeIn, 1'b0, mines, cycles, busyOk, timedOut);
      total++;
      if (mines !== expMines) begin
        bad++; $display("[TB] FAIL rand_mines[%0d]: got %h want %h (seed %h a %h c %h m %h n %0d)", t, mines, expMines, seed, a, c, m, nm);
      end
      total++;
      if (cycles != expLat || timedOut || !busyOk) begin
        bad++; $display("[TB] FAIL rand_timing[%0d]: got %0d want %0d busyOk %0d", t, cycles, expLat, busyOk);
      end
    end
  endtask

  initial begin
    inReset = 1'b1;
    inStart = 1'b0;
    inSeed = '0; inMult = '0; inIncrement = '0; inModulus = '0; inNumMines = '0;
`ifdef MINE_PLACER_SAFE_CELL_EN
    safeCell = '0;
`endif
    test_reset();
    test_directed();
    test_clamp();
    test_reset_midrun();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
